// File: rtl/seg_scan_decoder.sv
// Receiver for the multiplexed seven-segment bus: rebuilds per-digit hex values
// and decimal points from SEG_SEL/SEG_DATA once a pattern has been held stable.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned NUM_DIG    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           SEG_DATA,
  input  logic [NUM_DIG-1:0]   SEG_SEL,
  output logic [4*NUM_DIG-1:0] digit_val,
  output logic [NUM_DIG-1:0]   digit_dp,
  output logic [NUM_DIG-1:0]   dig_valid,
  output logic [NUM_DIG-1:0]   dig_err,
  output logic                 upd,
  output logic [2:0]           upd_idx,
  output logic                 sel_err
);

  localparam int unsigned SAMP_W    = NUM_DIG + 8;
  localparam int unsigned VAL_W     = 4 * NUM_DIG;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned VAL_IDX_W = $clog2(VAL_W);
  localparam logic [3:0]  CNT_MAX   = 4'(STABLE_CNT);

  logic [SAMP_W-1:0]    r_s_q;
  logic [SAMP_W-1:0]    r_prev;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [NUM_DIG-1:0]   w_sel;
  logic                 w_multi;
  logic                 w_commit;
  logic [IDX_W-1:0]     w_idx;
  logic                 r_cm_vld;
  logic [IDX_W-1:0]     r_cm_idx;
  logic [7:0]           r_cm_data;
  logic [3:0]           w_code;
  logic                 w_legal;
  logic                 w_blank;
  logic [3:0]           w_new_val;
  logic                 w_new_err;
  logic                 w_changed;
  logic [VAL_IDX_W-1:0] w_base;

  assign w_sel   = r_s_q[SAMP_W-1:8];
  assign w_multi = |(w_sel & (w_sel - NUM_DIG'(1)));

  // Stability counter: blank or multi-hot select restarts, a fresh pattern starts at 1
  always_comb begin
    w_cnt_nxt = 4'd1;
    if (w_sel == '0 || w_multi) begin
      w_cnt_nxt = 4'd0;
    end else if (r_s_q == r_prev) begin
      w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;
    end
  end

  assign w_commit = (w_cnt_nxt == CNT_MAX) && (r_cnt != CNT_MAX);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (w_sel[i]) w_idx = IDX_W'(i);
    end
  end

  // Sample register, stability counter and commit capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q     <= '0;
      r_prev    <= '0;
      r_cnt     <= '0;
      r_cm_vld  <= 1'b0;
      r_cm_idx  <= '0;
      r_cm_data <= '0;
    end else begin
      r_s_q     <= {SEG_SEL, SEG_DATA};
      r_prev    <= r_s_q;
      r_cnt     <= w_cnt_nxt;
      r_cm_vld  <= w_commit;
      r_cm_idx  <= w_idx;
      r_cm_data <= r_s_q[7:0];
    end
  end

  always_comb begin
    w_code  = 4'h0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (r_cm_data[6:0])
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h77: w_code = 4'hA;
      7'h7C: w_code = 4'hB;
      7'h39: w_code = 4'hC;
      7'h5E: w_code = 4'hD;
      7'h79: w_code = 4'hE;
      7'h71: w_code = 4'hF;
      7'h00: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_new_val = w_legal ? w_code : 4'h0;
  assign w_new_err = !w_legal && !w_blank;
  assign w_base    = VAL_IDX_W'({r_cm_idx, 2'b00});
  assign w_changed = {w_new_val, r_cm_data[7], w_legal, w_new_err} !=
                     {digit_val[w_base +: 4], digit_dp[r_cm_idx],
                      dig_valid[r_cm_idx], dig_err[r_cm_idx]};

  // Digit storage; only the committed digit is written
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_val <= '0;
      digit_dp  <= '0;
      dig_valid <= '0;
      dig_err   <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      sel_err   <= 1'b0;
    end else begin
      upd     <= 1'b0;
      sel_err <= w_multi;
      if (r_cm_vld) begin
        digit_val[w_base +: 4] <= w_new_val;
        digit_dp[r_cm_idx]     <= r_cm_data[7];
        dig_valid[r_cm_idx]    <= w_legal;
        dig_err[r_cm_idx]      <= w_new_err;
        upd                    <= w_changed;
        upd_idx                <= r_cm_idx;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: hand-written latency/reset/glitch sequences
// followed by a table of scan vectors checked against a per-digit expectation model.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  SEG_DATA;
  logic [4:0]  SEG_SEL;
  logic [19:0] digit_val;
  logic [4:0]  digit_dp;
  logic [4:0]  dig_valid;
  logic [4:0]  dig_err;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        sel_err;

  seg_scan_decoder #(.STABLE_CNT(4), .NUM_DIG(5)) dut (
    .clk(clk), .rst(rst), .SEG_DATA(SEG_DATA), .SEG_SEL(SEG_SEL),
    .digit_val(digit_val), .digit_dp(digit_dp), .dig_valid(dig_valid),
    .dig_err(dig_err), .upd(upd), .upd_idx(upd_idx), .sel_err(sel_err)
  );

  typedef struct {
    logic [4:0] sel;
    logic [7:0] data;
    int         hold;
    int         blank;
    logic [3:0] val;
    logic       vld;
    logic       err;
    logic       dp;
    int         upd_n;
  } vec_t;

  localparam int NV = 24;
  vec_t vt[NV];

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int serr_cnt = 0;

  logic [3:0] m_val[5];
  logic [4:0] m_vld, m_err, m_dp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (upd) upd_cnt = upd_cnt + 1;
    if (sel_err) serr_cnt = serr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] s, input logic [7:0] d, input int h,
                              input int b, input logic [3:0] v, input logic vl,
                              input logic e, input logic p, input int u);
    vec_t r;
    r.sel = s; r.data = d; r.hold = h; r.blank = b;
    r.val = v; r.vld = vl; r.err = e; r.dp = p; r.upd_n = u;
    return r;
  endfunction

  function automatic int sel2idx(input logic [4:0] s);
    int r = 0;
    for (int i = 0; i < 5; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic logic [19:0] pack_val();
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = m_val[i];
    return r;
  endfunction

  task automatic drive(input logic [4:0] s, input logic [7:0] d);
    SEG_SEL  = s;
    SEG_DATA = d;
  endtask

  initial begin
    logic [7:0] glyph[5];
    logic [3:0] code[5];
    int u0, s0, idx;

    glyph[0] = 8'h3F; glyph[1] = 8'h06; glyph[2] = 8'h5B; glyph[3] = 8'h07; glyph[4] = 8'h71;
    code[0]  = 4'h0;  code[1]  = 4'h1;  code[2]  = 4'h2;  code[3]  = 4'h7;  code[4]  = 4'hF;
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < 5; d++)
        vt[s*5+d] = mk(5'(1 << d), glyph[d], 8, 2, code[d], 1'b1, 1'b0, 1'b0, (s == 0) ? 1 : 0);
    vt[15] = mk(5'b10000, 8'hBF, 8, 2, 4'h0, 1'b1, 1'b0, 1'b1, 1);
    vt[16] = mk(5'b00001, 8'h00, 6, 2, 4'h0, 1'b0, 1'b0, 1'b0, 1);
    vt[17] = mk(5'b00001, 8'h00, 6, 2, 4'h0, 1'b0, 1'b0, 1'b0, 0);
    vt[18] = mk(5'b00010, 8'h06, 3, 2, 4'h1, 1'b1, 1'b0, 1'b0, 0);
    vt[19] = mk(5'b00100, 8'h7C, 4, 2, 4'hB, 1'b1, 1'b0, 1'b0, 1);
    vt[20] = mk(5'b01000, 8'h5E, 5, 2, 4'hD, 1'b1, 1'b0, 1'b0, 1);
    vt[21] = mk(5'b00010, 8'h08, 4, 2, 4'h0, 1'b0, 1'b1, 1'b0, 1);
    vt[22] = mk(5'b10000, 8'h79, 6, 0, 4'hE, 1'b1, 1'b0, 1'b0, 1);
    vt[23] = mk(5'b00001, 8'hF1, 6, 2, 4'hF, 1'b1, 1'b0, 1'b1, 1);

    // Reset state
    rst = 1'b1;
    drive(5'b00000, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_val", 32'(digit_val), 32'h0);
    chk("rst_valid", 32'(dig_valid), 32'h0);
    chk("rst_err", 32'(dig_err), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);

    // Digit 2 shows 5: exact commit latency and single pulse
    #5; u0 = upd_cnt;
    drive(5'b00100, 8'h6D);
    tick(5);
    chk("lat_early_upd", 32'(upd), 32'h0);
    chk("lat_early_valid", 32'(dig_valid), 32'h0);
    tick(1);
    chk("lat_upd", 32'(upd), 32'h1);
    chk("lat_idx", 32'(upd_idx), 32'd2);
    chk("lat_val", 32'(digit_val), 32'h00500);
    chk("lat_valid", 32'(dig_valid), 32'b00100);
    tick(1);
    chk("lat_pulse_len", 32'(upd), 32'h0);
    tick(20);
    #5;
    chk("hold_no_recommit", 32'(upd_cnt - u0), 32'd1);

    // Short 06 glitch then 4F on digit 0
    u0 = upd_cnt;
    drive(5'b00001, 8'h06);
    tick(3);
    drive(5'b00001, 8'h4F);
    tick(8);
    #5;
    chk("glitch_val", 32'(digit_val), 32'h00503);
    chk("glitch_valid", 32'(dig_valid), 32'b00101);
    chk("glitch_upd", 32'(upd_cnt - u0), 32'd1);

    // Illegal glyph with dp on digit 1
    u0 = upd_cnt;
    drive(5'b00010, 8'hC9);
    tick(8);
    #5;
    chk("ill_err", 32'(dig_err), 32'b00010);
    chk("ill_valid", 32'(dig_valid), 32'b00101);
    chk("ill_dp", 32'(digit_dp), 32'b00010);
    chk("ill_val", 32'(digit_val), 32'h00503);
    chk("ill_upd", 32'(upd_cnt - u0), 32'd1);

    // Multi-hot select
    u0 = upd_cnt; s0 = serr_cnt;
    drive(5'b00011, 8'h3F);
    tick(5);
    drive(5'b00000, 8'h00);
    tick(3);
    #5;
    chk("mh_selerr", 32'(serr_cnt - s0), 32'd5);
    chk("mh_upd", 32'(upd_cnt - u0), 32'd0);
    chk("mh_val", 32'(digit_val), 32'h00503);
    chk("mh_err", 32'(dig_err), 32'b00010);

    // Table-driven scans and corner vectors
    m_val[0] = 4'h3; m_val[1] = 4'h0; m_val[2] = 4'h5; m_val[3] = 4'h0; m_val[4] = 4'h0;
    m_vld = 5'b00101; m_err = 5'b00010; m_dp = 5'b00010;
    s0 = upd_cnt;
    for (int k = 0; k < NV; k++) begin
      u0 = upd_cnt;
      drive(vt[k].sel, vt[k].data);
      tick(vt[k].hold);
      if (vt[k].blank > 0) begin
        drive(5'b00000, 8'h00);
        tick(vt[k].blank);
      end
      #5;
      idx = sel2idx(vt[k].sel);
      m_val[idx] = vt[k].val;
      m_vld[idx] = vt[k].vld;
      m_err[idx] = vt[k].err;
      m_dp[idx]  = vt[k].dp;
      chk($sformatf("v%0d_val", k), 32'(digit_val), 32'(pack_val()));
      chk($sformatf("v%0d_valid", k), 32'(dig_valid), 32'(m_vld));
      chk($sformatf("v%0d_err", k), 32'(dig_err), 32'(m_err));
      chk($sformatf("v%0d_dp", k), 32'(digit_dp), 32'(m_dp));
      chk($sformatf("v%0d_upd", k), 32'(upd_cnt - u0), 32'(vt[k].upd_n));
      if (k == 14) begin
        chk("scan_val", 32'(digit_val), 32'hF7210);
        chk("scan_valid", 32'(dig_valid), 32'b11111);
        chk("scan_upd_total", 32'(upd_cnt - s0), 32'd5);
      end
    end

    // Reset in the middle of a pending window on digit 3
    drive(5'b01000, 8'h66);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_val", 32'(digit_val), 32'h0);
    chk("midrst_valid", 32'(dig_valid), 32'h0);
    chk("midrst_dp", 32'(digit_dp), 32'h0);
    chk("midrst_upd", 32'(upd), 32'h0);
    rst = 1'b0;
    tick(5);
    chk("midrst_no_early", 32'(dig_valid), 32'h0);
    tick(1);
    chk("midrst_valid_after", 32'(dig_valid), 32'b01000);
    chk("midrst_val_after", 32'(digit_val), 32'h04000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
